// File: rtl/pixel_packer_pkg.sv
// Shared video constants for the pixel packer: FSM state encoding, default geometry,
// frame counter width and the clog2 helper used to size the slot counter.
package pixel_packer_pkg;

  localparam int DEFAULT_PIXEL_WIDTH     = 8;
  localparam int DEFAULT_PIXELS_PER_WORD = 4;
  localparam int FRAME_COUNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_PACK     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pixel_shift_reg.sv
// Word assembly register for the pixel packer: loads one pixel into a slot, can clear,
// and presents the word including the pixel being loaded this cycle.
module pixel_shift_reg
  import pixel_packer_pkg::*;
#(
  parameter int  PIXEL_WIDTH     = DEFAULT_PIXEL_WIDTH,
  parameter int  PIXELS_PER_WORD = DEFAULT_PIXELS_PER_WORD,
  localparam int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_WORD,
  localparam int SLOT_WIDTH      = clog2(PIXELS_PER_WORD)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [SLOT_WIDTH-1:0]  slot,
  input  logic [PIXEL_WIDTH-1:0] pixel,
  output logic [DATA_WIDTH-1:0]  packed_word
);

  logic [DATA_WIDTH-1:0] word_r;
  logic [DATA_WIDTH-1:0] base_s;

  assign base_s = clear ? {DATA_WIDTH{1'b0}} : word_r;

  // Slot 0 sits in the MSBs; each slot takes the new pixel or keeps its stored value.
  always_comb begin
    packed_word = base_s;
    for (int s = 0; s < PIXELS_PER_WORD; s++) begin
      packed_word[DATA_WIDTH-(s+1)*PIXEL_WIDTH +: PIXEL_WIDTH] =
        (load && (slot == SLOT_WIDTH'(s))) ? pixel
                                           : base_s[DATA_WIDTH-(s+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  // Storage for the partially assembled word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_r <= {DATA_WIDTH{1'b0}};
    end else begin
      word_r <= packed_word;
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Pixel packer: aligns to frame start and packs PIXELS_PER_WORD pixels per FIFO write.
// Optional frame-start counter on oFrameCount when PIXEL_PACKER_FRAME_CNT_EN is defined.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int  PIXEL_WIDTH     = DEFAULT_PIXEL_WIDTH,
  parameter int  PIXELS_PER_WORD = DEFAULT_PIXELS_PER_WORD,
  localparam int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_WORD
) (
  input  logic                         iClk,
  input  logic                         iResetN,
  input  logic                         iEnable,
  input  logic [PIXEL_WIDTH-1:0]       iPixel,
  input  logic                         iPixelValid,
  input  logic                         iFrameStart,
  input  logic                         iFull,
  output logic [DATA_WIDTH-1:0]        oData,
  output logic                         oWrEn,
  output logic                         oOverflow,
  output logic [FRAME_COUNT_WIDTH-1:0] oFrameCount
);

  localparam int                    SLOT_WIDTH = clog2(PIXELS_PER_WORD);
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT  = SLOT_WIDTH'(PIXELS_PER_WORD - 1);
  localparam logic [SLOT_WIDTH-1:0] SLOT_ZERO  = {SLOT_WIDTH{1'b0}};
  localparam logic [SLOT_WIDTH-1:0] SLOT_ONE   = SLOT_WIDTH'(1);

  state_t                state_r;
  logic [SLOT_WIDTH-1:0] slot_r;
  logic [SLOT_WIDTH-1:0] load_slot_s;
  logic                  sof_s;
  logic                  load_s;
  logic                  clear_s;
  logic [DATA_WIDTH-1:0] packed_word_s;

  // A frame start only counts once capture is armed (any state other than IDLE).
  assign sof_s = iEnable && iPixelValid && iFrameStart && (state_r != ST_IDLE);

  // Steer the word register: frame starts restart at slot 0, disabling drops the partial word.
  always_comb begin
    load_s      = 1'b0;
    clear_s     = 1'b0;
    load_slot_s = SLOT_ZERO;
    if (!iEnable) begin
      clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_WAIT_SOF, ST_DROP: begin
          load_s  = sof_s;
          clear_s = sof_s;
        end
        ST_PACK: begin
          load_s  = iPixelValid;
          clear_s = sof_s;
        end
        default: begin
          load_s  = 1'b0;
          clear_s = 1'b0;
        end
      endcase
    end
    if (sof_s) begin
      load_slot_s = SLOT_ZERO;
    end else begin
      load_slot_s = slot_r;
    end
  end

  pixel_shift_reg #(
    .PIXEL_WIDTH     (PIXEL_WIDTH),
    .PIXELS_PER_WORD (PIXELS_PER_WORD)
  ) u_shift_reg (
    .clk         (iClk),
    .rst_n       (iResetN),
    .clear       (clear_s),
    .load        (load_s),
    .slot        (load_slot_s),
    .pixel       (iPixel),
    .packed_word (packed_word_s)
  );

  // Control FSM, slot counter and registered FIFO-side outputs.
  always_ff @(posedge iClk) begin
    if (!iResetN) begin
      state_r   <= ST_IDLE;
      slot_r    <= SLOT_ZERO;
      oData     <= {DATA_WIDTH{1'b0}};
      oWrEn     <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oWrEn <= 1'b0;
      if (!iEnable) begin
        state_r <= ST_IDLE;
        slot_r  <= SLOT_ZERO;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r   <= ST_WAIT_SOF;
            slot_r    <= SLOT_ZERO;
            oOverflow <= 1'b0;
          end
          ST_WAIT_SOF, ST_DROP: begin
            if (sof_s) begin
              state_r <= ST_PACK;
              slot_r  <= SLOT_ONE;
            end
          end
          ST_PACK: begin
            if (sof_s) begin
              slot_r <= SLOT_ONE;
            end else if (iPixelValid) begin
              if (slot_r == LAST_SLOT) begin
                slot_r <= SLOT_ZERO;
                if (iFull) begin
                  oOverflow <= 1'b1;
                  state_r   <= ST_DROP;
                end else begin
                  oWrEn <= 1'b1;
                  oData <= packed_word_s;
                end
              end else begin
                slot_r <= slot_r + SLOT_ONE;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            slot_r  <= SLOT_ZERO;
          end
        endcase
      end
    end
  end

`ifdef PIXEL_PACKER_FRAME_CNT_EN
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_r;

  // Accepted frame starts, wrapping naturally at the counter width.
  always_ff @(posedge iClk) begin
    if (!iResetN) begin
      frame_count_r <= {FRAME_COUNT_WIDTH{1'b0}};
    end else if (sof_s) begin
      frame_count_r <= frame_count_r + {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  assign oFrameCount = frame_count_r;
`else
  assign oFrameCount = {FRAME_COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per input pixel.
REQ-002 SHALL have parameter PIXELS_PER_WORD, default 4, pixels per FIFO word (>=2).
REQ-003 SHALL derive localparam DATA_WIDTH = PIXEL_WIDTH*PIXELS_PER_WORD, the FIFO word width.
REQ-004 SHALL have port iClk, input, 1, sole clock; all logic is on its rising edge.
REQ-005 SHALL have port iResetN, input, 1, synchronous active-low reset.
REQ-006 SHALL have port iEnable, input, 1, capture enable.
REQ-007 SHALL have port iPixel, input, PIXEL_WIDTH, pixel data.
REQ-008 SHALL have port iPixelValid, input, 1, iPixel qualifier.
REQ-009 SHALL have port iFrameStart, input, 1, first pixel of frame; meaningful only with iPixelValid.
REQ-010 SHALL have port iFull, input, 1, FIFO full flag.
REQ-011 SHALL have port oData, output, DATA_WIDTH, packed word to FIFO.
REQ-012 SHALL have port oWrEn, output, 1, FIFO write strobe.
REQ-013 SHALL have port oOverflow, output, 1, sticky word-lost flag.
REQ-014 SHALL have port oFrameCount, output, 16, accepted frames (see Configuration).

Function
REQ-015 SHALL implement states IDLE, WAIT_SOF, PACK, DROP.
REQ-016 IDLE SHALL ignore pixels; iEnable=1 -> WAIT_SOF and oOverflow cleared.
REQ-017 WAIT_SOF SHALL discard pixels until iPixelValid&iFrameStart; that pixel becomes slot 0 -> PACK.
REQ-018 PACK SHALL store each valid pixel in the next slot; slot 0 occupies oData MSBs, slot PIXELS_PER_WORD-1 the LSBs.
REQ-019 On the cycle filling the last slot with iFull=0, SHALL on the next edge drive oData with the word and oWrEn=1 for exactly one cycle; slot counter returns to 0.
REQ-020 On the cycle filling the last slot with iFull=1, SHALL discard the word, set oOverflow, enter DROP.
REQ-021 DROP SHALL discard pixels until iPixelValid&iFrameStart; that pixel becomes slot 0 -> PACK.
REQ-022 iFrameStart with valid in PACK at slot !=0 SHALL discard the partial word and restart at slot 0 with the new pixel; no write.
REQ-023 iEnable=0 in any state SHALL go to IDLE on the next edge, discarding any partial word; partial words are never written.
REQ-024 oData SHALL hold its last written value while oWrEn=0.
REQ-025 Slot counter width SHALL be CLOG2(PIXELS_PER_WORD); wrap only via REQ-019/022/023.
REQ-026 Back-to-back valid pixels every cycle SHALL sustain one write per PIXELS_PER_WORD cycles without loss while iFull=0.

Reset
REQ-027 iResetN=0 at an edge SHALL force IDLE, slot 0, oData=0, oWrEn=0, oOverflow=0, oFrameCount=0, overriding all other inputs including mid-word.

Configuration
REQ-028 With macro PIXEL_PACKER_FRAME_CNT_EN defined, oFrameCount SHALL increment (mod 2^16, 0xFFFF->0x0000) on each frame start accepted per REQ-017/021/022.
REQ-029 Without PIXEL_PACKER_FRAME_CNT_EN, oFrameCount SHALL be constant 0 and no counter logic synthesised.

Structure
REQ-030 SHALL obtain CLOG2 from the shared common.v header; state encodings and PIXEL_WIDTH/PIXELS_PER_WORD defaults SHALL live in shared video constants so fifoInterface-side widths match.
REQ-031 Word assembly SHALL be a sub-module pixel_shift_reg (load-slot, clear, parallel out); FSM and counters stay in pixel_packer.

Verification
REQ-032 Enable, SOF+0x11, 0x22, 0x33, 0x44 consecutive -> oData=0x11223344, oWrEn high one cycle, one edge after 0x44 accepted.
REQ-033 Pixels 0xAA,0xBB before any SOF, then SOF 0x01..0x04 -> only 0x01020304 written.
REQ-034 iFull=1 while 4th pixel arrives -> no oWrEn, oOverflow=1; next 8 non-SOF pixels dropped; SOF 0x05..0x08 with iFull=0 -> 0x05060708 written, oOverflow stays 1.
REQ-035 SOF 0x10,0x20, then SOF 0x30,0x40,0x50,0x60 -> single write 0x30405060.
REQ-036 iResetN=0 after 2 pixels -> all outputs 0; then 2 more pixels without SOF -> no write.
REQ-037 With PIXEL_PACKER_FRAME_CNT_EN, 3 SOFs -> oFrameCount=3; preload to 0xFFFF via 65535 SOFs, one more -> 0x0000.
